switch_conditioner: RTL and testbench

//  Upstream input stage for the FPGA device's sliding switches. Registers raw board

---
 rtl/switch_conditioner.sv | 174 +++++++++++++++++
 tb/tb_switch_conditioner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
// switch_conditioner
// Input stage for the board's sliding switches. Each channel goes through a
// two-flop synchroniser and then a counter-based debounce FSM; the debounced
// levels drive the data-memory IO ports (bit 0 -> io_sw0, bit 1 -> io_sw1).
//
// Build option:
//   SWCOND_EDGE_EN  when defined, sw_rise/sw_fall carry registered one-cycle
//                   pulses on every change of sw_out. When undefined they are
//                   tied low and no edge registers exist.
//
// A new level is accepted only after DEBOUNCE_CYCLES consecutive synchronised
// samples disagree with the current stable level. A raw level held from edge k
// reaches sw_out at edge k + DEBOUNCE_CYCLES + 1 (two synchroniser edges, then
// DEBOUNCE_CYCLES counted edges). CNT_W must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

module switch_conditioner #(
  parameter int NUM_SW          = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_out,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall
);

  // Debounce FSM: a stable state per level plus a qualifying state for each
  // direction of change.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } deb_state_t;

  // Count value reached on the last agreeing sample before a level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a one-sample debounce the first disagreeing sample is already enough,
  // so the WAIT states are skipped entirely.
  localparam bit SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);

  logic [NUM_SW-1:0] sync0;
  logic [NUM_SW-1:0] sync1;

  // Two-flop synchroniser bringing the asynchronous pins into the clock domain.
  // NOTE: sequential state always uses <=, so every flop samples the values
  // from before the edge and sync1 really lags sync0 by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= sw_raw;
      sync1 <= sync0;
    end
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             out_q;
`ifdef SWCOND_EDGE_EN
    logic             rise_q;
    logic             fall_q;
`endif

    // Per-channel debounce FSM with registered level and edge outputs.
    always_ff @(posedge clock) begin
      if (reset) begin
        // A pending change is discarded: the channel restarts from a clean low.
        state  <= STABLE_LO;
        cnt    <= '0;
        out_q  <= 1'b0;
`ifdef SWCOND_EDGE_EN
        rise_q <= 1'b0;
        fall_q <= 1'b0;
`endif
      end else begin
`ifdef SWCOND_EDGE_EN
        // NOTE: pulses get a default of 0 every cycle and are only raised on
        // the edge that changes out_q, which makes them exactly one cycle long.
        rise_q <= 1'b0;
        fall_q <= 1'b0;
`endif
        case (state)
          STABLE_LO: begin
            if (sync1[i]) begin
              if (SINGLE_SAMPLE) begin
                state  <= STABLE_HI;
                out_q  <= 1'b1;
                cnt    <= '0;
`ifdef SWCOND_EDGE_EN
                rise_q <= 1'b1;
`endif
              end else begin
                state <= WAIT_HI;
                cnt   <= CNT_ONE;
              end
            end
          end

          WAIT_HI: begin
            if (!sync1[i]) begin
              // A single low sample means the input bounced; start over.
              state <= STABLE_LO;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state  <= STABLE_HI;
              out_q  <= 1'b1;
              cnt    <= '0;
`ifdef SWCOND_EDGE_EN
              rise_q <= 1'b1;
`endif
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end

          STABLE_HI: begin
            if (!sync1[i]) begin
              if (SINGLE_SAMPLE) begin
                state  <= STABLE_LO;
                out_q  <= 1'b0;
                cnt    <= '0;
`ifdef SWCOND_EDGE_EN
                fall_q <= 1'b1;
`endif
              end else begin
                state <= WAIT_LO;
                cnt   <= CNT_ONE;
              end
            end
          end

          WAIT_LO: begin
            if (sync1[i]) begin
              // A single high sample means the input bounced; start over.
              state <= STABLE_HI;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state  <= STABLE_LO;
              out_q  <= 1'b0;
              cnt    <= '0;
`ifdef SWCOND_EDGE_EN
              fall_q <= 1'b1;
`endif
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end

          default: begin
            state <= STABLE_LO;
            cnt   <= '0;
            out_q <= 1'b0;
          end
        endcase
      end
    end

    assign sw_out[i]  = out_q;
`ifdef SWCOND_EDGE_EN
    assign sw_rise[i] = rise_q;
    assign sw_fall[i] = fall_q;
`else
    assign sw_rise[i] = 1'b0;
    assign sw_fall[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner
// Directed bench for switch_conditioner with NUM_SW=2, DEBOUNCE_CYCLES=4.
// The stimulus thread applies one raw/reset vector per clock edge and queues
// the outputs expected right after that edge; a monitor thread pops and
// compares on the following falling edge.

module tb_switch_conditioner;

  localparam int NUM_SW          = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int CNT_W           = 4;

`ifdef SWCOND_EDGE_EN
  localparam logic [1:0] EDGE_MASK = 2'b11;
`else
  localparam logic [1:0] EDGE_MASK = 2'b00;
`endif

  logic              clock;
  logic              reset;
  logic [NUM_SW-1:0] sw_raw;
  logic [NUM_SW-1:0] sw_out;
  logic [NUM_SW-1:0] sw_rise;
  logic [NUM_SW-1:0] sw_fall;

  switch_conditioner #(
    .NUM_SW         (NUM_SW),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .sw_raw (sw_raw),
    .sw_out (sw_out),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned tag;
    logic [1:0]  out;
    logic [1:0]  rise;
    logic [1:0]  fall;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc;
  int          checks;
  int          failures;

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare the expectation tagged for the edge just taken.
  always @(negedge clock) begin
    if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (sw_out !== e.out) begin
        failures++;
        $display("FAIL %s sw_out edge %0d: got %b expected %b", e.name, cyc, sw_out, e.out);
      end
      checks++;
      if (sw_rise !== e.rise) begin
        failures++;
        $display("FAIL %s sw_rise edge %0d: got %b expected %b", e.name, cyc, sw_rise, e.rise);
      end
      checks++;
      if (sw_fall !== e.fall) begin
        failures++;
        $display("FAIL %s sw_fall edge %0d: got %b expected %b", e.name, cyc, sw_fall, e.fall);
      end
    end
  end

  // One edge: apply inputs, queue the outputs expected right after the edge.
  task automatic step(input logic rst, input logic [1:0] raw, input logic [1:0] out,
                      input logic [1:0] rise, input logic [1:0] fall, input string name);
    exp_t e;
    e.tag  = cyc + 1;
    e.out  = out;
    e.rise = rise & EDGE_MASK;
    e.fall = fall & EDGE_MASK;
    e.name = name;
    exp_q.push_back(e);
    reset  = rst;
    sw_raw = raw;
    @(posedge clock);
    #1;
  endtask

  // Several edges with the same inputs and a steady output, no pulses.
  task automatic hold(input int n, input logic rst, input logic [1:0] raw,
                      input logic [1:0] out, input string name);
    for (int i = 0; i < n; i++) step(rst, raw, out, 2'b00, 2'b00, name);
  endtask

  initial begin
    reset  = 1'b1;
    sw_raw = 2'b11;

    // 1. Reset with switches on, then release: level appears on the 6th edge.
    hold(3, 1'b1, 2'b11, 2'b00, "reset_hold");
    hold(5, 1'b0, 2'b11, 2'b00, "post_reset_wait");
    step(1'b0, 2'b11, 2'b11, 2'b11, 2'b00, "post_reset_rise");
    hold(1, 1'b0, 2'b11, 2'b11, "post_reset_steady");

    // Bring channel 0 low while channel 1 stays high.
    hold(5, 1'b0, 2'b10, 2'b11, "ch0_fall_wait");
    step(1'b0, 2'b10, 2'b10, 2'b00, 2'b01, "ch0_fall");
    hold(2, 1'b0, 2'b10, 2'b10, "ch0_low_steady");

    // 3. Bounce: three high samples then low, never accepted.
    hold(3, 1'b0, 2'b11, 2'b10, "bounce_high");
    hold(8, 1'b0, 2'b10, 2'b10, "bounce_reject");

    // 2. Clean rise on channel 0: not at k+4, exactly at k+5.
    hold(5, 1'b0, 2'b11, 2'b10, "ch0_rise_wait");
    step(1'b0, 2'b11, 2'b11, 2'b01, 2'b00, "ch0_rise");
    hold(1, 1'b0, 2'b11, 2'b11, "ch0_high_steady");

    // Channel 0 low again for the restart case.
    hold(5, 1'b0, 2'b10, 2'b11, "ch0_fall2_wait");
    step(1'b0, 2'b10, 2'b10, 2'b00, 2'b01, "ch0_fall2");
    hold(2, 1'b0, 2'b10, 2'b10, "ch0_low2_steady");

    // 4. High 3, low 1, then high steady: rise 5 edges after the final rise.
    hold(3, 1'b0, 2'b11, 2'b10, "restart_high1");
    hold(1, 1'b0, 2'b10, 2'b10, "restart_glitch");
    hold(5, 1'b0, 2'b11, 2'b10, "restart_wait");
    step(1'b0, 2'b11, 2'b11, 2'b01, 2'b00, "restart_rise");
    hold(1, 1'b0, 2'b11, 2'b11, "restart_steady");

    // 5. Both channels fall together.
    hold(5, 1'b0, 2'b00, 2'b11, "dual_fall_wait");
    step(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, "dual_fall");
    hold(1, 1'b0, 2'b00, 2'b00, "dual_low_steady");

    // 6. Reset while channel 1 sits in WAIT_HI with cnt=2; the edge that would
    //    have accepted the level is inside reset, and the count restarts.
    hold(4, 1'b0, 2'b10, 2'b00, "mid_wait");
    hold(2, 1'b1, 2'b10, 2'b00, "mid_reset");
    hold(5, 1'b0, 2'b10, 2'b00, "after_reset_wait");
    step(1'b0, 2'b10, 2'b10, 2'b10, 2'b00, "after_reset_rise");
    hold(1, 1'b0, 2'b10, 2'b10, "after_reset_steady");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
